// File: rtl/div_arbiter.sv
// Arbitrates one iterative divider between two EX pipes: oldest-first grant,
// start/done sequencing, local divide-by-zero, and flush absorption via DRAIN.
module div_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid_i,
    input  logic [2*DATA_W-1:0]   req_a_i,
    input  logic [2*DATA_W-1:0]   req_b_i,
    input  logic [3:0]            req_op_i,
    input  logic                  older_i,
    input  logic [1:0]            pipe_stall_i,
    input  logic [1:0]            pipe_clr_i,
    output logic [1:0]            stall_o,
    output logic [1:0]            result_valid_o,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  div_start_o,
    output logic [DATA_W-1:0]     div_a_o,
    output logic [DATA_W-1:0]     div_b_o,
    output logic                  div_signed_o,
    input  logic                  div_done_i,
    input  logic [DATA_W-1:0]     div_q_i,
    input  logic [DATA_W-1:0]     div_r_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic [1:0]          elig;
    logic                gnt;
    logic [DATA_W-1:0]   gnt_a, gnt_b;
    logic [1:0]          gnt_op;

    // Divide-by-zero follows the RISC-V convention: quotient all-ones, remainder = dividend.
    function automatic logic [DATA_W-1:0] div0_result(input logic [DATA_W-1:0] a,
                                                      input logic              is_mod);
        div0_result = is_mod ? a : {DATA_W{1'b1}};
    endfunction

    always_comb begin
        elig   = req_valid_i & ~pipe_clr_i;
        gnt    = (elig == 2'b11) ? older_i : elig[1];
        gnt_a  = gnt ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
        gnt_b  = gnt ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
        gnt_op = gnt ? req_op_i[3:2] : req_op_i[1:0];
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        res_d          = res_q;
        stall_o        = elig;
        result_valid_o = 2'b00;
        result_o       = '0;
        div_start_o    = 1'b0;
        div_a_o        = a_q;
        div_b_o        = b_q;
        div_signed_o   = op_q[0];

        unique case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    owner_d = gnt;
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    op_d    = gnt_op;
                    if (gnt_b == '0) begin
                        res_d   = div0_result(gnt_a, gnt_op[1]);
                        state_d = DONE;
                    end else begin
                        div_start_o  = 1'b1;
                        div_a_o      = gnt_a;
                        div_b_o      = gnt_b;
                        div_signed_o = gnt_op[0];
                        state_d      = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o[owner_q] = 1'b1;
                // Owner flush wins over done; a done in the same cycle is simply dropped.
                if (pipe_clr_i[owner_q]) begin
                    state_d = div_done_i ? IDLE : DRAIN;
                end else if (div_done_i) begin
                    res_d   = op_q[1] ? div_r_i : div_q_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                stall_o[owner_q] = 1'b0;
                if (!pipe_clr_i[owner_q]) begin
                    result_valid_o[owner_q] = 1'b1;
                    if (owner_q) result_o[2*DATA_W-1:DATA_W] = res_q;
                    else         result_o[DATA_W-1:0]        = res_q;
                end
                if (pipe_clr_i[owner_q] || !pipe_stall_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (div_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter; the bench plays the divider with hand-computed results.
module tb_div_arbiter;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst;
    logic [1:0]          req_valid_i;
    logic [2*DATA_W-1:0] req_a_i, req_b_i;
    logic [3:0]          req_op_i;
    logic                older_i;
    logic [1:0]          pipe_stall_i, pipe_clr_i;
    logic [1:0]          stall_o, result_valid_o;
    logic [2*DATA_W-1:0] result_o;
    logic                div_start_o, div_signed_o;
    logic [DATA_W-1:0]   div_a_o, div_b_o;
    logic                div_done_i;
    logic [DATA_W-1:0]   div_q_i, div_r_i;

    int n_checks = 0;
    int n_errors = 0;

    div_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_op_i(req_op_i), .older_i(older_i),
        .pipe_stall_i(pipe_stall_i), .pipe_clr_i(pipe_clr_i),
        .stall_o(stall_o), .result_valid_o(result_valid_o), .result_o(result_o),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_signed_o(div_signed_o),
        .div_done_i(div_done_i), .div_q_i(div_q_i), .div_r_i(div_r_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [1:0] op);
        req_valid_i[p] = v;
        if (p == 1) begin
            req_a_i[2*DATA_W-1:DATA_W] = a;
            req_b_i[2*DATA_W-1:DATA_W] = b;
            req_op_i[3:2]              = op;
        end else begin
            req_a_i[DATA_W-1:0] = a;
            req_b_i[DATA_W-1:0] = b;
            req_op_i[1:0]       = op;
        end
    endtask

    task automatic clear_inputs();
        req_valid_i  = 2'b00;
        req_a_i      = '0;
        req_b_i      = '0;
        req_op_i     = 4'b0000;
        older_i      = 1'b0;
        pipe_stall_i = 2'b00;
        pipe_clr_i   = 2'b00;
        div_done_i   = 1'b0;
        div_q_i      = '0;
        div_r_i      = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        settle();
        n_checks++;
        if ({stall_o, result_valid_o, div_start_o, div_signed_o} !== 6'b0 ||
            result_o !== '0 || div_a_o !== '0 || div_b_o !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: stall=%b rv=%b start=%b res=%h a=%h b=%h, required all 0",
                     stall_o, result_valid_o, div_start_o, result_o, div_a_o, div_b_o);
        end
    endtask

    task automatic test_basic_div();
        int bad_stall = 0;
        tick();
        set_req(0, 1'b1, 32'd100, 32'd7, 2'b00);
        settle();
        n_checks++;
        if (div_start_o !== 1'b1 || div_a_o !== 32'd100 || div_b_o !== 32'd7 ||
            div_signed_o !== 1'b0 || stall_o !== 2'b01) begin
            n_errors++;
            $display("FAIL basic_grant: start=%b a=%0d b=%0d sgn=%b stall=%b, required 1 100 7 0 01",
                     div_start_o, div_a_o, div_b_o, div_signed_o, stall_o);
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 10) begin
                div_done_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
            end
            settle();
            if (stall_o !== 2'b01 || div_start_o !== 1'b0 || result_valid_o !== 2'b00) bad_stall++;
        end
        n_checks++;
        if (bad_stall != 0) begin
            n_errors++;
            $display("FAIL basic_busy: %0d bad cycles in 1..10, required 0 (stall=01, no start, no valid)",
                     bad_stall);
        end
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b01 || result_o[DATA_W-1:0] !== 32'd14 || stall_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_result: rv=%b res0=%0d stall=%b, required rv=01 res0=14 stall0=0",
                     result_valid_o, result_o[DATA_W-1:0], stall_o);
        end
        tick();
        set_req(0, 1'b0, '0, '0, 2'b00);
        settle();
        n_checks++;
        if (result_valid_o !== 2'b00 || div_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_back_idle: rv=%b start=%b, required 00 0", result_valid_o, div_start_o);
        end
    endtask

    task automatic test_oldest_first();
        tick();
        older_i = 1'b1;
        set_req(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 2'b11);
        set_req(0, 1'b1, 32'd9, 32'd3, 2'b00);
        settle();
        n_checks++;
        if (div_start_o !== 1'b1 || div_a_o !== 32'hFFFF_FFF9 || div_signed_o !== 1'b1 ||
            stall_o !== 2'b11) begin
            n_errors++;
            $display("FAIL oldest_grant: start=%b a=%h sgn=%b stall=%b, required 1 fffffff9 1 11",
                     div_start_o, div_a_o, div_signed_o, stall_o);
        end
        tick();
        div_done_i = 1'b1; div_q_i = 32'hFFFF_FFFD; div_r_i = 32'hFFFF_FFFF;
        settle();
        n_checks++;
        if (stall_o !== 2'b11) begin
            n_errors++;
            $display("FAIL oldest_busy_stall: stall=%b, required 11", stall_o);
        end
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b10 || result_o[2*DATA_W-1:DATA_W] !== 32'hFFFF_FFFF ||
            stall_o !== 2'b01) begin
            n_errors++;
            $display("FAIL oldest_mod_result: rv=%b res1=%h stall=%b, required 10 ffffffff 01",
                     result_valid_o, result_o[2*DATA_W-1:DATA_W], stall_o);
        end
        tick();
        set_req(1, 1'b0, '0, '0, 2'b00);
        settle();
        n_checks++;
        if (div_start_o !== 1'b1 || div_a_o !== 32'd9 || div_b_o !== 32'd3 || stall_o !== 2'b01) begin
            n_errors++;
            $display("FAIL second_grant: start=%b a=%0d b=%0d stall=%b, required 1 9 3 01",
                     div_start_o, div_a_o, div_b_o, stall_o);
        end
        tick();
        div_done_i = 1'b1; div_q_i = 32'd3; div_r_i = 32'd0;
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b01 || result_o[DATA_W-1:0] !== 32'd3) begin
            n_errors++;
            $display("FAIL second_result: rv=%b res0=%0d, required 01 3",
                     result_valid_o, result_o[DATA_W-1:0]);
        end
        tick();
        set_req(0, 1'b0, '0, '0, 2'b00);
        older_i = 1'b0;
    endtask

    task automatic test_div_zero(input logic is_mod, input logic [DATA_W-1:0] expect_res);
        tick();
        set_req(0, 1'b1, 32'h1234, 32'd0, {is_mod, 1'b0});
        settle();
        n_checks++;
        if (div_start_o !== 1'b0 || stall_o !== 2'b01) begin
            n_errors++;
            $display("FAIL div0_grant(mod=%b): start=%b stall=%b, required 0 01",
                     is_mod, div_start_o, stall_o);
        end
        tick();
        settle();
        n_checks++;
        if (result_valid_o !== 2'b01 || result_o[DATA_W-1:0] !== expect_res) begin
            n_errors++;
            $display("FAIL div0_result(mod=%b): rv=%b res0=%h, required 01 %h",
                     is_mod, result_valid_o, result_o[DATA_W-1:0], expect_res);
        end
        tick();
        set_req(0, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic test_flush_drain();
        tick();
        set_req(0, 1'b1, 32'd100, 32'd7, 2'b00);
        tick();
        set_req(1, 1'b1, 32'd50, 32'd5, 2'b00);
        settle();
        n_checks++;
        if (stall_o !== 2'b11) begin
            n_errors++;
            $display("FAIL flush_busy_stall: stall=%b, required 11", stall_o);
        end
        tick();
        pipe_clr_i = 2'b01;
        tick();
        pipe_clr_i = 2'b00;
        set_req(0, 1'b0, '0, '0, 2'b00);
        settle();
        n_checks++;
        if (stall_o !== 2'b10 || div_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_stall: stall=%b start=%b, required 10 0", stall_o, div_start_o);
        end
        tick();
        div_done_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b00 || div_start_o !== 1'b0 || stall_o !== 2'b10) begin
            n_errors++;
            $display("FAIL drain_done: rv=%b start=%b stall=%b, required 00 0 10",
                     result_valid_o, div_start_o, stall_o);
        end
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (div_start_o !== 1'b1 || div_a_o !== 32'd50 || result_valid_o !== 2'b00) begin
            n_errors++;
            $display("FAIL post_drain_grant: start=%b a=%0d rv=%b, required 1 50 00",
                     div_start_o, div_a_o, result_valid_o);
        end
        tick();
        div_done_i = 1'b1; div_q_i = 32'd10; div_r_i = 32'd0;
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b10 || result_o[2*DATA_W-1:DATA_W] !== 32'd10) begin
            n_errors++;
            $display("FAIL post_drain_result: rv=%b res1=%0d, required 10 10",
                     result_valid_o, result_o[2*DATA_W-1:DATA_W]);
        end
        tick();
        set_req(1, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic test_done_hold();
        int bad_hold = 0;
        tick();
        set_req(0, 1'b1, 32'd9, 32'd3, 2'b00);
        tick();
        div_done_i = 1'b1; div_q_i = 32'd3; div_r_i = 32'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            div_done_i = 1'b0;
            div_q_i    = 32'hDEAD_BEEF;
            pipe_stall_i = (c < 3) ? 2'b01 : 2'b00;
            settle();
            if (result_valid_o !== 2'b01 || result_o[DATA_W-1:0] !== 32'd3) bad_hold++;
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_errors++;
            $display("FAIL done_hold: %0d of 4 cycles lost rv=01/res0=3", bad_hold);
        end
        tick();
        set_req(0, 1'b0, '0, '0, 2'b00);
        settle();
        n_checks++;
        if (result_valid_o !== 2'b00 || div_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL done_release: rv=%b start=%b, required 00 0", result_valid_o, div_start_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        tick();
        set_req(0, 1'b1, 32'd100, 32'd7, 2'b00);
        tick();
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, 2'b00);
        tick();
        rst = 1'b0;
        div_done_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
        settle();
        n_checks++;
        if (stall_o !== 2'b00 || result_valid_o !== 2'b00 || div_start_o !== 1'b0 ||
            result_o !== '0) begin
            n_errors++;
            $display("FAIL reset_stale_done: stall=%b rv=%b start=%b res=%h, required all 0",
                     stall_o, result_valid_o, div_start_o, result_o);
        end
        tick();
        div_done_i = 1'b0;
        settle();
        n_checks++;
        if (result_valid_o !== 2'b00 || div_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_after_stale: rv=%b start=%b, required 00 0",
                     result_valid_o, div_start_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_div();
        test_oldest_first();
        test_div_zero(1'b0, 32'hFFFF_FFFF);
        test_div_zero(1'b1, 32'h0000_1234);
        test_flush_drain();
        test_done_hold();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
